// File: rtl/obstacle_scheduler.sv
// Purpose: spawns, scrolls and retires dino-game obstacles on each running game tick, with spacing and a speed ramp.
// Latency: one cycle; every output is a register updated on the edge that samples the tick.
// Backpressure: none; the design is paced only by the tick enable, and consumers sample the outputs each cycle.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   i_game_tick      one-cycle 60 Hz tick pulse; acts only while i_run is high
//   i_run            game running; ticks are ignored when low
//   i_clear          game-start pulse, returns all state to its reset values
//   i_rng            random byte; [1:0] gates a spawn, [7:5] picks the sprite type
//   o_obs_pos        packed x-positions, channel k at [k*POS_W +: POS_W]
//   o_obs_type       packed sprite types, same packing as o_obs_pos
//   o_obs_active     per-channel valid flag
//   o_speed          current scroll speed in px/tick
//   o_spawn_pulse    high for the one cycle after a spawn
module obstacle_scheduler #(
  parameter int NUM_OBS        = 2,
  parameter int POS_W          = 9,
  parameter int TYPE_W         = 3,
  parameter int NUM_TYPES      = 5,
  parameter int SPAWN_X        = 250,
  parameter int MIN_GAP        = 64,
  parameter int SPEED_INIT     = 1,
  parameter int SPEED_MAX      = 4,
  parameter int SPEED_UP_TICKS = 600
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_game_tick,
  input  logic                      i_run,
  input  logic                      i_clear,
  input  logic [7:0]                i_rng,
  output logic [NUM_OBS*POS_W-1:0]  o_obs_pos,
  output logic [NUM_OBS*TYPE_W-1:0] o_obs_type,
  output logic [NUM_OBS-1:0]        o_obs_active,
  output logic [2:0]                o_speed,
  output logic                      o_spawn_pulse
);

  localparam int CNT_W = (SPEED_UP_TICKS > 1) ? $clog2(SPEED_UP_TICKS) : 1;

  localparam logic [POS_W-1:0] SPAWN_POS = POS_W'(SPAWN_X);
  // A surviving obstacle must be at or left of this line before a new one may appear.
  localparam logic [POS_W-1:0] GAP_LIMIT = POS_W'(SPAWN_X - MIN_GAP);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPEED_UP_TICKS - 1);
  localparam logic [2:0]       SPD_INIT  = 3'(SPEED_INIT);
  localparam logic [2:0]       SPD_MAX   = 3'(SPEED_MAX);
  localparam logic [3:0]       TYPES_4   = 4'(NUM_TYPES);

  // Elaboration-time guard against parameter sets the logic is not built for.
  generate
    if (NUM_OBS < 1 || NUM_OBS > 4) begin : g_bad_num_obs
      $error("obstacle_scheduler: NUM_OBS must be 1..4");
    end
    if (NUM_TYPES < 4 || NUM_TYPES > 8) begin : g_bad_num_types
      $error("obstacle_scheduler: NUM_TYPES must be 4..8");
    end
    if (SPAWN_X < MIN_GAP || SPAWN_X >= (1 << POS_W)) begin : g_bad_spawn
      $error("obstacle_scheduler: SPAWN_X must fit POS_W and be >= MIN_GAP");
    end
    if (SPEED_MAX > 7 || SPEED_INIT > SPEED_MAX) begin : g_bad_speed
      $error("obstacle_scheduler: speeds must fit 3 bits with SPEED_INIT <= SPEED_MAX");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [POS_W-1:0]  r_pos    [NUM_OBS];
  logic [TYPE_W-1:0] r_type   [NUM_OBS];
  logic [NUM_OBS-1:0] r_active;
  logic [2:0]        r_speed;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_spawn_pulse;

  // ---------------------------------------------------------------------------
  // Next-state terms
  // ---------------------------------------------------------------------------
  logic              w_update;
  logic [POS_W-1:0]  w_speed_ext;
  logic [NUM_OBS-1:0] w_retire;
  logic [NUM_OBS-1:0] w_mv_act;
  logic [POS_W-1:0]  w_mv_pos [NUM_OBS];
  logic              w_gap_ok;
  logic [NUM_OBS-1:0] w_cand_oh;
  logic              w_rng_gate;
  logic              w_spawn;
  logic [2:0]        w_rng_type;
  logic [2:0]        w_fold_type;
  logic [TYPE_W-1:0] w_spawn_type;
  logic              w_cnt_wrap;
  logic [2:0]        w_speed_inc;
  logic              w_unused_rng;

  assign w_update    = i_game_tick & i_run;
  assign w_speed_ext = POS_W'(r_speed);

  // Move: an obstacle that cannot scroll a full step has left the screen.
  // Checking before subtracting keeps the position from wrapping.
  always_comb begin
    w_retire = '0;
    w_mv_act = '0;
    for (int k = 0; k < NUM_OBS; k++) begin
      w_mv_pos[k] = '0;
      if (r_active[k]) begin
        if (r_pos[k] < w_speed_ext) begin
          w_retire[k] = 1'b1;
        end else begin
          w_mv_act[k] = 1'b1;
          w_mv_pos[k] = r_pos[k] - w_speed_ext;
        end
      end
    end
  end

  // Gap rule looks at post-move positions of the survivors only.
  always_comb begin
    w_gap_ok = 1'b1;
    for (int k = 0; k < NUM_OBS; k++) begin
      if (w_mv_act[k] && (w_mv_pos[k] > GAP_LIMIT)) begin
        w_gap_ok = 1'b0;
      end
    end
  end

  // Lowest clear bit of the pre-tick active vector, one-hot. Using the
  // pre-tick flags means a channel retired on this tick is never picked.
  // When every channel is active the increment wraps to 0 and no bit is set.
  assign w_cand_oh = ~r_active & (r_active + NUM_OBS'(1));

  assign w_rng_gate = (i_rng[1:0] != 2'b00);
  assign w_spawn    = w_update & (|w_cand_oh) & w_gap_ok & w_rng_gate;

  // Fold the 3-bit random type into 0..NUM_TYPES-1 with a single subtract.
  assign w_rng_type   = i_rng[7:5];
  assign w_fold_type  = ({1'b0, w_rng_type} < TYPES_4) ? w_rng_type
                                                        : 3'({1'b0, w_rng_type} - TYPES_4);
  assign w_spawn_type = TYPE_W'(w_fold_type);

  assign w_cnt_wrap  = (r_cnt == CNT_LAST);
  assign w_speed_inc = (r_speed < SPD_MAX) ? (r_speed + 3'd1) : r_speed;

  // i_rng[4:2] carry no meaning here.
  assign w_unused_rng = ^i_rng[4:2];

  // ---------------------------------------------------------------------------
  // Registers. Clear shares the reset path; a tick coinciding with clear is
  // swallowed, so no spawn pulse can follow a clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      for (int k = 0; k < NUM_OBS; k++) begin
        r_pos[k]  <= '0;
        r_type[k] <= '0;
      end
      r_active      <= '0;
      r_speed       <= SPD_INIT;
      r_cnt         <= '0;
      r_spawn_pulse <= 1'b0;
    end else if (w_update) begin
      for (int k = 0; k < NUM_OBS; k++) begin
        if (w_spawn && w_cand_oh[k]) begin
          r_pos[k]    <= SPAWN_POS;
          r_type[k]   <= w_spawn_type;
          r_active[k] <= 1'b1;
        end else begin
          r_pos[k]    <= w_mv_pos[k];
          // Inactive channels present type 0, so a retiring channel drops its type.
          r_type[k]   <= w_mv_act[k] ? r_type[k] : '0;
          r_active[k] <= w_mv_act[k];
        end
      end
      r_spawn_pulse <= w_spawn;
      if (w_cnt_wrap) begin
        r_cnt   <= '0;
        r_speed <= w_speed_inc;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_spawn_pulse <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: direct register taps, packed per channel.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_obs_pos  = '0;
    o_obs_type = '0;
    for (int k = 0; k < NUM_OBS; k++) begin
      o_obs_pos[k*POS_W +: POS_W]   = r_pos[k];
      o_obs_type[k*TYPE_W +: TYPE_W] = r_type[k];
    end
  end

  assign o_obs_active  = r_active;
  assign o_speed       = r_speed;
  assign o_spawn_pulse = r_spawn_pulse;

endmodule

// File: tb/tb_obstacle_scheduler.sv
module tb_obstacle_scheduler;

  localparam int NUM_OBS        = 2;
  localparam int POS_W          = 9;
  localparam int TYPE_W         = 3;
  localparam int NUM_TYPES      = 5;
  localparam int SPAWN_X        = 250;
  localparam int MIN_GAP        = 64;
  localparam int SPEED_INIT     = 1;
  localparam int SPEED_MAX      = 4;
  localparam int SPEED_UP_TICKS = 600;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_game_tick = 1'b0;
  logic i_run = 1'b0;
  logic i_clear = 1'b0;
  logic [7:0] i_rng = 8'h00;
  logic [NUM_OBS*POS_W-1:0]  o_obs_pos;
  logic [NUM_OBS*TYPE_W-1:0] o_obs_type;
  logic [NUM_OBS-1:0]        o_obs_active;
  logic [2:0]                o_speed;
  logic                      o_spawn_pulse;

  always #5 clk = ~clk;

  obstacle_scheduler #(
    .NUM_OBS(NUM_OBS), .POS_W(POS_W), .TYPE_W(TYPE_W), .NUM_TYPES(NUM_TYPES),
    .SPAWN_X(SPAWN_X), .MIN_GAP(MIN_GAP), .SPEED_INIT(SPEED_INIT),
    .SPEED_MAX(SPEED_MAX), .SPEED_UP_TICKS(SPEED_UP_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .i_game_tick(i_game_tick), .i_run(i_run),
    .i_clear(i_clear), .i_rng(i_rng), .o_obs_pos(o_obs_pos),
    .o_obs_type(o_obs_type), .o_obs_active(o_obs_active),
    .o_speed(o_speed), .o_spawn_pulse(o_spawn_pulse)
  );

  typedef struct packed {
    logic [NUM_OBS*POS_W-1:0]  pos;
    logic [NUM_OBS*TYPE_W-1:0] typ;
    logic [NUM_OBS-1:0]        act;
    logic [2:0]                spd;
    logic                      pulse;
  } snap_t;

  snap_t sb_q[$];
  snap_t exp_s;
  snap_t got_s;
  int n_checks = 0;
  int n_pass = 0;

  // Reference model state
  int m_pos  [NUM_OBS];
  int m_type [NUM_OBS];
  bit m_act  [NUM_OBS];
  int m_speed;
  int m_cnt;
  bit m_pulse;

  function automatic snap_t model_snap();
    snap_t s;
    for (int k = 0; k < NUM_OBS; k++) begin
      s.pos[k*POS_W +: POS_W]    = POS_W'(m_pos[k]);
      s.typ[k*TYPE_W +: TYPE_W]  = TYPE_W'(m_type[k]);
      s.act[k]                   = m_act[k];
    end
    s.spd   = 3'(m_speed);
    s.pulse = m_pulse;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.pos   = o_obs_pos;
    s.typ   = o_obs_type;
    s.act   = o_obs_active;
    s.spd   = o_speed;
    s.pulse = o_spawn_pulse;
    return s;
  endfunction

  // One clock cycle: advance the model, queue its expectation, drive the DUT.
  task automatic step(input logic r, input logic tick, input logic run,
                      input logic clr, input logic [7:0] rng);
    bit pre [NUM_OBS];
    bit gap;
    int cand;
    int t;
    if (r || clr) begin
      for (int k = 0; k < NUM_OBS; k++) begin
        m_pos[k] = 0; m_type[k] = 0; m_act[k] = 1'b0;
      end
      m_speed = SPEED_INIT; m_cnt = 0; m_pulse = 1'b0;
    end else if (tick && run) begin
      for (int k = 0; k < NUM_OBS; k++) pre[k] = m_act[k];
      for (int k = 0; k < NUM_OBS; k++) begin
        if (m_act[k]) begin
          if (m_pos[k] < m_speed) begin
            m_act[k] = 1'b0; m_pos[k] = 0; m_type[k] = 0;
          end else begin
            m_pos[k] = m_pos[k] - m_speed;
          end
        end
      end
      gap = 1'b1;
      for (int k = 0; k < NUM_OBS; k++)
        if (m_act[k] && m_pos[k] > SPAWN_X - MIN_GAP) gap = 1'b0;
      cand = -1;
      for (int k = NUM_OBS - 1; k >= 0; k--)
        if (!pre[k]) cand = k;
      t = int'(rng[7:5]);
      if (t >= NUM_TYPES) t = t - NUM_TYPES;
      m_pulse = (cand >= 0) && gap && (rng[1:0] != 2'b00);
      if (m_pulse) begin
        m_pos[cand] = SPAWN_X; m_act[cand] = 1'b1; m_type[cand] = t;
      end
      if (m_cnt == SPEED_UP_TICKS - 1) begin
        m_cnt = 0;
        if (m_speed < SPEED_MAX) m_speed = m_speed + 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      m_pulse = 1'b0;
    end
    sb_q.push_back(model_snap());
    rst = r; i_game_tick = tick; i_run = run; i_clear = clr; i_rng = rng;
    @(posedge clk);
    #1;
    rst = 1'b0; i_game_tick = 1'b0; i_clear = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_reset got=%h exp=%h", got_s, exp_s); else n_pass++;
    n_checks++;
    if (o_obs_active !== 2'b00 || o_obs_pos !== '0 || o_obs_type !== '0)
      $display("FAIL reset_state act=%b pos=%h typ=%h want 0", o_obs_active, o_obs_pos, o_obs_type);
    else n_pass++;
    n_checks++;
    if (o_speed !== 3'd1 || o_spawn_pulse !== 1'b0)
      $display("FAIL reset_speed speed=%0d pulse=%b want 1/0", o_speed, o_spawn_pulse);
    else n_pass++;
    // Tick while reset held: nothing may happen
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h61);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_reset_tick got=%h exp=%h", got_s, exp_s); else n_pass++;
    n_checks++;
    if (o_obs_active !== 2'b00 || o_spawn_pulse !== 1'b0)
      $display("FAIL reset_tick act=%b pulse=%b want 00/0", o_obs_active, o_spawn_pulse);
    else n_pass++;
  endtask

  task automatic test_spawn();
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'b011_00001);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_spawn got=%h exp=%h", got_s, exp_s); else n_pass++;
    n_checks++;
    if (o_obs_active !== 2'b01 || o_obs_pos[8:0] !== 9'd250 || o_obs_type[2:0] !== 3'd3 || o_spawn_pulse !== 1'b1)
      $display("FAIL spawn_first act=%b pos=%0d typ=%0d pulse=%b want 01/250/3/1",
               o_obs_active, o_obs_pos[8:0], o_obs_type[2:0], o_spawn_pulse);
    else n_pass++;
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_spawn_idle got=%h exp=%h", got_s, exp_s); else n_pass++;
    n_checks++;
    if (o_spawn_pulse !== 1'b0 || o_obs_pos[8:0] !== 9'd250)
      $display("FAIL spawn_pulse_width pulse=%b pos=%0d want 0/250", o_spawn_pulse, o_obs_pos[8:0]);
    else n_pass++;
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'b011_00000);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_spawn_move got=%h exp=%h", got_s, exp_s); else n_pass++;
    n_checks++;
    if (o_obs_pos[8:0] !== 9'd249 || o_spawn_pulse !== 1'b0 || o_obs_active !== 2'b01)
      $display("FAIL spawn_move pos=%0d pulse=%b act=%b want 249/0/01",
               o_obs_pos[8:0], o_spawn_pulse, o_obs_active);
    else n_pass++;
  endtask

  task automatic test_spacing();
    int found;
    int pulses;
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_spacing_clear got=%h exp=%h", got_s, exp_s); else n_pass++;
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h61);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_spacing_ch0 got=%h exp=%h", got_s, exp_s); else n_pass++;
    found = -1;
    for (int n = 1; n <= 100 && found < 0; n++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h01);
      exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
      if (got_s !== exp_s) $display("FAIL sb_spacing_%0d got=%h exp=%h", n, got_s, exp_s); else n_pass++;
      if (o_obs_active[1] === 1'b1) found = n;
    end
    n_checks++;
    if (found != 64 || o_obs_pos[8:0] !== 9'd186)
      $display("FAIL spacing_tick ch1 spawned on tick %0d with ch0 at %0d, want 64/186",
               found, o_obs_pos[8:0]);
    else n_pass++;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h01);
      exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
      if (got_s !== exp_s) $display("FAIL sb_spacing_full got=%h exp=%h", got_s, exp_s); else n_pass++;
      if (o_spawn_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || o_obs_active !== 2'b11)
      $display("FAIL spacing_full pulses=%0d act=%b want 0/11", pulses, o_obs_active);
    else n_pass++;
  endtask

  task automatic test_type_fold();
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_fold_clear got=%h exp=%h", got_s, exp_s); else n_pass++;
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'b111_00001);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_fold7 got=%h exp=%h", got_s, exp_s); else n_pass++;
    n_checks++;
    if (o_obs_type[2:0] !== 3'd2) $display("FAIL fold_7 type=%0d want 2", o_obs_type[2:0]);
    else n_pass++;
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_fold_clear2 got=%h exp=%h", got_s, exp_s); else n_pass++;
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'b100_00001);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_fold4 got=%h exp=%h", got_s, exp_s); else n_pass++;
    n_checks++;
    if (o_obs_type[2:0] !== 3'd4) $display("FAIL fold_4 type=%0d want 4", o_obs_type[2:0]);
    else n_pass++;
  endtask

  task automatic test_retire();
    int bad;
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_retire_clear got=%h exp=%h", got_s, exp_s); else n_pass++;
    // Spawn on update 598 so ch0 sits at an odd position when speed becomes 2.
    bad = 0;
    for (int n = 0; n < 724; n++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, (n == 598) ? 8'h01 : 8'h00);
      exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
      if (got_s !== exp_s) begin
        if (bad < 5) $display("FAIL sb_retire_%0d got=%h exp=%h", n, got_s, exp_s);
        bad++;
      end else n_pass++;
    end
    n_checks++;
    if (o_obs_pos[8:0] !== 9'd1 || o_speed !== 3'd2 || o_obs_active !== 2'b01)
      $display("FAIL retire_setup pos=%0d speed=%0d act=%b want 1/2/01",
               o_obs_pos[8:0], o_speed, o_obs_active);
    else n_pass++;
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h61);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_retire_tick got=%h exp=%h", got_s, exp_s); else n_pass++;
    n_checks++;
    if (o_obs_active[0] !== 1'b0 || o_obs_pos[8:0] !== 9'd0 || o_obs_type[2:0] !== 3'd0)
      $display("FAIL retire_ch0 act=%b pos=%0d typ=%0d want 0/0/0",
               o_obs_active[0], o_obs_pos[8:0], o_obs_type[2:0]);
    else n_pass++;
    n_checks++;
    if (o_obs_active[1] !== 1'b1 || o_obs_pos[17:9] !== 9'd250 || o_spawn_pulse !== 1'b1)
      $display("FAIL retire_spawn_ch1 act=%b pos=%0d pulse=%b want 1/250/1",
               o_obs_active[1], o_obs_pos[17:9], o_spawn_pulse);
    else n_pass++;
  endtask

  task automatic test_speed();
    int bad;
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_speed_clear got=%h exp=%h", got_s, exp_s); else n_pass++;
    bad = 0;
    for (int n = 0; n < 599; n++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
      if (got_s !== exp_s) begin
        if (bad < 5) $display("FAIL sb_speed_a%0d got=%h exp=%h", n, got_s, exp_s);
        bad++;
      end else n_pass++;
    end
    // Ticks with run low must not count
    for (int n = 0; n < 5; n++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h61);
      exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
      if (got_s !== exp_s) $display("FAIL sb_speed_norun got=%h exp=%h", got_s, exp_s); else n_pass++;
    end
    n_checks++;
    if (o_speed !== 3'd1 || o_obs_active !== 2'b00)
      $display("FAIL speed_599_norun speed=%0d act=%b want 1/00", o_speed, o_obs_active);
    else n_pass++;
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_speed_600 got=%h exp=%h", got_s, exp_s); else n_pass++;
    n_checks++;
    if (o_speed !== 3'd2) $display("FAIL speed_600 speed=%0d want 2", o_speed); else n_pass++;
    for (int n = 0; n < 1200; n++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
      if (got_s !== exp_s) begin
        if (bad < 5) $display("FAIL sb_speed_b%0d got=%h exp=%h", n, got_s, exp_s);
        bad++;
      end else n_pass++;
    end
    n_checks++;
    if (o_speed !== 3'd4) $display("FAIL speed_1800 speed=%0d want 4", o_speed); else n_pass++;
    // Random traffic while saturated
    for (int n = 0; n < 1200; n++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom));
      exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
      if (got_s !== exp_s) begin
        if (bad < 5) $display("FAIL sb_speed_rand%0d got=%h exp=%h", n, got_s, exp_s);
        bad++;
      end else n_pass++;
    end
    n_checks++;
    if (o_speed !== 3'd4) $display("FAIL speed_3000 speed=%0d want 4", o_speed); else n_pass++;
    // Clear together with a tick: clear wins, no pulse
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h61);
    exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
    if (got_s !== exp_s) $display("FAIL sb_speed_clr got=%h exp=%h", got_s, exp_s); else n_pass++;
    n_checks++;
    if (o_speed !== 3'd1 || o_obs_active !== 2'b00 || o_spawn_pulse !== 1'b0 || o_obs_pos !== '0)
      $display("FAIL clear_midrun speed=%0d act=%b pulse=%b pos=%h want 1/00/0/0",
               o_speed, o_obs_active, o_spawn_pulse, o_obs_pos);
    else n_pass++;
    // Counter restarted from 0: 599 updates keep speed 1, the 600th raises it
    for (int n = 0; n < 600; n++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      exp_s = sb_q.pop_front(); got_s = dut_snap(); n_checks++;
      if (got_s !== exp_s) begin
        if (bad < 5) $display("FAIL sb_speed_c%0d got=%h exp=%h", n, got_s, exp_s);
        bad++;
      end else n_pass++;
      if (n == 598) begin
        n_checks++;
        if (o_speed !== 3'd1) $display("FAIL clear_cnt_599 speed=%0d want 1", o_speed); else n_pass++;
      end
    end
    n_checks++;
    if (o_speed !== 3'd2) $display("FAIL clear_cnt_600 speed=%0d want 2", o_speed); else n_pass++;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_spawn();
    test_spacing();
    test_type_fold();
    test_retire();
    test_speed();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sb_drain left=%0d want 0", sb_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
